// File: rtl/pc_seq_unit.sv
// pc_seq_unit: fetch PC sequencer with redirect, stall, call/ret; circular RAS enabled by PC_RAS_EN.
module pc_seq_unit #(
  parameter int ADDR_W = 16,
  parameter int STEP = 1,
  parameter int RESET_VEC = 0,
  parameter int RAS_DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           stall,
  input  logic                           redirect,
  input  logic [ADDR_W-1:0]              redirect_addr,
  input  logic                           call,
  input  logic [ADDR_W-1:0]              call_target,
  input  logic                           ret,
  output logic [ADDR_W-1:0]              pc_out,
  output logic [$clog2(RAS_DEPTH):0]     ras_count,
  output logic                           ras_ovf,
  output logic                           ras_unf
);
  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = PW + 1;
  logic [ADDR_W-1:0] pc_q, pc_d, pc_inc;
  assign pc_inc = pc_q + ADDR_W'(STEP);
  assign pc_out = pc_q;
`ifdef PC_RAS_EN
  logic [ADDR_W-1:0] ras_q [RAS_DEPTH];
  logic [PW-1:0] sp_q, sp_d, top, widx;
  logic [CW-1:0] cnt_q, cnt_d;
  logic ovf_q, ovf_d, unf_q, unf_d, we;
  assign top = sp_q - 1'b1;
  // sp_q is the next free slot; when full it also marks the oldest entry
  always_comb begin
    pc_d = pc_inc;
    sp_d = sp_q;
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    unf_d = unf_q;
    we = 1'b0;
    widx = sp_q;
    if (redirect) pc_d = redirect_addr;
    else if (stall) pc_d = pc_q;
    else if (call && ret) begin
      pc_d = call_target;
      we = 1'b1;
      widx = (cnt_q == '0) ? sp_q : top;
      sp_d = (cnt_q == '0) ? sp_q + 1'b1 : sp_q;
      cnt_d = (cnt_q == '0) ? CW'(1) : cnt_q;
    end else if (call) begin
      pc_d = call_target;
      we = 1'b1;
      sp_d = sp_q + 1'b1;
      ovf_d = ovf_q | (cnt_q == CW'(RAS_DEPTH));
      cnt_d = (cnt_q == CW'(RAS_DEPTH)) ? cnt_q : cnt_q + 1'b1;
    end else if (ret) begin
      pc_d = (cnt_q != '0) ? ras_q[top] : pc_inc;
      sp_d = (cnt_q != '0) ? top : sp_q;
      cnt_d = (cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
      unf_d = unf_q | (cnt_q == '0);
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q <= ADDR_W'(RESET_VEC);
      sp_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      pc_q <= pc_d;
      sp_q <= sp_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end
  always_ff @(posedge clk)
    if (!reset && we) ras_q[widx] <= pc_inc;
  assign ras_count = cnt_q;
  assign ras_ovf = ovf_q;
  assign ras_unf = unf_q;
`else
  always_comb begin
    pc_d = redirect ? redirect_addr : stall ? pc_q : call ? call_target : pc_inc;
  end
  always_ff @(posedge clk) begin
    if (reset) pc_q <= ADDR_W'(RESET_VEC);
    else pc_q <= pc_d;
  end
  assign ras_count = '0;
  assign ras_ovf = 1'b0;
  assign ras_unf = 1'b0;
`endif
endmodule
